// File: rtl/ac97_pkg.sv
// Shared AC'97 scheduler definitions: FSM states, register-index width,
// the power-up init table and slot-word formatting helpers.
package ac97_pkg;

   localparam int AC97_IDX_W = 7;

   typedef enum logic [2:0] {
      ST_WAIT_RDY,
      ST_INIT,
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT_RD
   } ac97_state_t;

   typedef struct packed {
      logic [AC97_IDX_W-1:0] idx;
      logic [15:0]           data;
   } ac97_init_entry_t;

   // Power-up writes: master/headphone volume unmuted, PCM-out volume 0x0808, record select.
   function automatic ac97_init_entry_t ac97_init_entry(input int i);
      ac97_init_entry_t e;
      case (i)
         0:       e = {7'h02, 16'h0000};
         1:       e = {7'h04, 16'h0000};
         2:       e = {7'h18, 16'h0808};
         3:       e = {7'h1A, 16'h0000};
         default: e = {7'h00, 16'h0000};
      endcase
      return e;
   endfunction

   function automatic logic [19:0] ac97_slot1(input logic rd, input logic [AC97_IDX_W-1:0] idx);
      return {rd, idx, 12'h000};
   endfunction

   function automatic logic [19:0] ac97_slot2(input logic [15:0] wdata);
      return {wdata, 4'h0};
   endfunction

endpackage

// File: rtl/ac97_rr_arb2.sv
// Two-way round-robin arbiter; the favoured requester wins ties and the
// favour flips to the other requester whenever a grant is taken.
module ac97_rr_arb2 (
   input  logic       ac97_bitclk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic rr;

   always_comb begin
      grant = 2'b00;
      if (rr) grant = req[1] ? 2'b10 : {1'b0, req[0]};
      else    grant = req[0] ? 2'b01 : {req[1], 1'b0};
   end

   always_ff @(posedge ac97_bitclk or posedge rst) begin
      if (rst)          rr <= 1'b0;
      else if (advance) rr <= grant[0];
   end

endmodule

// File: rtl/ac97_cmd_sched.sv
// AC'97 codec register-access scheduler: issues the init table after codec
// ready, then arbitrates host/mixer accesses onto the slot-1/slot-2 channel.
module ac97_cmd_sched
   import ac97_pkg::*;
#(
   parameter int RD_TIMEOUT_FRAMES = 4,
   parameter int INIT_LEN          = 4
) (
   input  logic        ac97_bitclk,
   input  logic        rst,
   input  logic        frame_start,
   input  logic        codec_ready,
   input  logic [1:0]  req_valid,
   input  logic [1:0]  req_read,
   input  logic [13:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [1:0]  req_ack,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic        cmd_valid,
   output logic [19:0] cmd_addr,
   output logic [19:0] cmd_data,
   input  logic        sts_valid,
   input  logic [6:0]  sts_addr,
   input  logic [15:0] sts_data,
   output logic        init_done
);

   localparam int CNT_W  = $clog2(RD_TIMEOUT_FRAMES + 1);
   localparam int IIDX_W = $clog2(INIT_LEN + 1);

   ac97_state_t           state, state_nxt;
   logic [IIDX_W-1:0]     init_idx, init_idx_nxt, init_sel;
   logic [CNT_W-1:0]      frame_cnt, frame_cnt_nxt, frame_cnt_inc;
   logic [1:0]            owner, owner_nxt;
   logic                  is_read, is_read_nxt;
   logic [AC97_IDX_W-1:0] cur_idx, cur_idx_nxt;
   logic                  cmd_valid_nxt, init_done_nxt, err_nxt;
   logic [19:0]           cmd_addr_nxt, cmd_data_nxt;
   logic [1:0]            ack_nxt;
   logic [15:0]           rdata_nxt;
   logic [1:0]            grant;
   logic                  arb_advance, gsel, g_read;
   logic [AC97_IDX_W-1:0] g_idx;
   logic [15:0]           g_wdata;
   ac97_init_entry_t      init_entry;

   ac97_rr_arb2 u_arb (
      .ac97_bitclk (ac97_bitclk),
      .rst         (rst),
      .req         (req_valid),
      .advance     (arb_advance),
      .grant       (grant)
   );

   assign gsel          = grant[1];
   assign g_read        = req_read[gsel];
   assign g_idx         = gsel ? req_addr[13:7] : req_addr[6:0];
   assign g_wdata       = gsel ? req_wdata[31:16] : req_wdata[15:0];
   assign frame_cnt_inc = frame_cnt + 1'b1;
   // Entry to present next: table[0] when leaving WAIT_RDY, else the one after idx.
   assign init_sel      = (state == ST_INIT) ? init_idx + 1'b1 : '0;
   assign init_entry    = ac97_init_entry(int'(init_sel));

   always_comb begin
      state_nxt     = state;
      init_idx_nxt  = init_idx;
      frame_cnt_nxt = frame_cnt;
      owner_nxt     = owner;
      is_read_nxt   = is_read;
      cur_idx_nxt   = cur_idx;
      cmd_valid_nxt = cmd_valid;
      cmd_addr_nxt  = cmd_addr;
      cmd_data_nxt  = cmd_data;
      init_done_nxt = init_done;
      ack_nxt       = 2'b00;
      rdata_nxt     = rsp_rdata;
      err_nxt       = rsp_err;
      arb_advance   = 1'b0;

      if (frame_start && !codec_ready && state != ST_WAIT_RDY) begin
         state_nxt     = ST_WAIT_RDY;
         cmd_valid_nxt = 1'b0;
         init_done_nxt = 1'b0;
         init_idx_nxt  = '0;
         if (state == ST_ISSUE || state == ST_WAIT_RD) begin
            ack_nxt   = owner;
            err_nxt   = 1'b1;
            rdata_nxt = 16'hFFFF;
         end
      end else begin
         case (state)
            ST_WAIT_RDY: begin
               if (frame_start && codec_ready) begin
                  state_nxt     = ST_INIT;
                  init_idx_nxt  = '0;
                  cmd_valid_nxt = 1'b1;
                  cmd_addr_nxt  = ac97_slot1(1'b0, init_entry.idx);
                  cmd_data_nxt  = ac97_slot2(init_entry.data);
               end
            end
            ST_INIT: begin
               if (frame_start) begin
                  if (init_idx == IIDX_W'(INIT_LEN - 1)) begin
                     cmd_valid_nxt = 1'b0;
                     init_done_nxt = 1'b1;
                     state_nxt     = ST_IDLE;
                  end else begin
                     init_idx_nxt = init_idx + 1'b1;
                     cmd_addr_nxt = ac97_slot1(1'b0, init_entry.idx);
                     cmd_data_nxt = ac97_slot2(init_entry.data);
                  end
               end
            end
            ST_IDLE: begin
               // Holding off while req_ack is high stops an acked request being re-granted.
               if (init_done && req_ack == 2'b00 && grant != 2'b00) begin
                  arb_advance   = 1'b1;
                  owner_nxt     = grant;
                  is_read_nxt   = g_read;
                  cur_idx_nxt   = g_idx;
                  cmd_valid_nxt = 1'b1;
                  cmd_addr_nxt  = ac97_slot1(g_read, g_idx);
                  cmd_data_nxt  = g_read ? 20'h00000 : ac97_slot2(g_wdata);
                  state_nxt     = ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (frame_start) begin
                  cmd_valid_nxt = 1'b0;
                  if (!is_read) begin
                     ack_nxt   = owner;
                     err_nxt   = 1'b0;
                     state_nxt = ST_IDLE;
                  end else begin
                     frame_cnt_nxt = '0;
                     state_nxt     = ST_WAIT_RD;
                  end
               end
            end
            ST_WAIT_RD: begin
               if (sts_valid && sts_addr == cur_idx) begin
                  ack_nxt   = owner;
                  rdata_nxt = sts_data;
                  err_nxt   = 1'b0;
                  state_nxt = ST_IDLE;
               end else if (frame_start) begin
                  if (frame_cnt_inc == CNT_W'(RD_TIMEOUT_FRAMES)) begin
                     ack_nxt   = owner;
                     rdata_nxt = 16'hFFFF;
                     err_nxt   = 1'b1;
                     state_nxt = ST_IDLE;
                  end else begin
                     frame_cnt_nxt = frame_cnt_inc;
                  end
               end
            end
            default: state_nxt = ST_WAIT_RDY;
         endcase
      end
   end

   always_ff @(posedge ac97_bitclk or posedge rst) begin
      if (rst) begin
         state     <= ST_WAIT_RDY;
         init_idx  <= '0;
         frame_cnt <= '0;
         owner     <= 2'b00;
         is_read   <= 1'b0;
         cur_idx   <= '0;
         cmd_valid <= 1'b0;
         cmd_addr  <= 20'h00000;
         cmd_data  <= 20'h00000;
         init_done <= 1'b0;
         req_ack   <= 2'b00;
         rsp_rdata <= 16'h0000;
         rsp_err   <= 1'b0;
      end else begin
         state     <= state_nxt;
         init_idx  <= init_idx_nxt;
         frame_cnt <= frame_cnt_nxt;
         owner     <= owner_nxt;
         is_read   <= is_read_nxt;
         cur_idx   <= cur_idx_nxt;
         cmd_valid <= cmd_valid_nxt;
         cmd_addr  <= cmd_addr_nxt;
         cmd_data  <= cmd_data_nxt;
         init_done <= init_done_nxt;
         req_ack   <= ack_nxt;
         rsp_rdata <= rdata_nxt;
         rsp_err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_ac97_cmd_sched.sv
// Self-checking bench for ac97_cmd_sched: a transaction-level model checked
// every cycle, plus directed scenarios with hand-computed literal expectations.
module tb_ac97_cmd_sched;

   localparam int FRAME_LEN = 8;

   logic        ac97_bitclk = 1'b0;
   logic        rst         = 1'b0;
   logic        frame_start = 1'b0;
   logic        codec_ready = 1'b0;
   logic [1:0]  req_valid   = 2'b00;
   logic [1:0]  req_read    = 2'b00;
   logic [13:0] req_addr    = '0;
   logic [31:0] req_wdata   = '0;
   logic        sts_valid   = 1'b0;
   logic [6:0]  sts_addr    = '0;
   logic [15:0] sts_data    = '0;
   logic [1:0]  req_ack;
   logic [15:0] rsp_rdata;
   logic        rsp_err;
   logic        cmd_valid;
   logic [19:0] cmd_addr;
   logic [19:0] cmd_data;
   logic        init_done;

   int vectors     = 0;
   int miscompares = 0;

   logic [6:0]  tbl_idx  [4] = '{7'h02, 7'h04, 7'h18, 7'h1A};
   logic [15:0] tbl_data [4] = '{16'h0000, 16'h0000, 16'h0808, 16'h0000};
   logic [19:0] exp_init_addr [4] = '{20'h02000, 20'h04000, 20'h18000, 20'h1A000};
   logic [19:0] exp_init_data [4] = '{20'h00000, 20'h00000, 20'h08080, 20'h00000};

   ac97_cmd_sched #(.RD_TIMEOUT_FRAMES(4), .INIT_LEN(4)) dut (
      .ac97_bitclk (ac97_bitclk),
      .rst         (rst),
      .frame_start (frame_start),
      .codec_ready (codec_ready),
      .req_valid   (req_valid),
      .req_read    (req_read),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_ack     (req_ack),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .cmd_valid   (cmd_valid),
      .cmd_addr    (cmd_addr),
      .cmd_data    (cmd_data),
      .sts_valid   (sts_valid),
      .sts_addr    (sts_addr),
      .sts_data    (sts_data),
      .init_done   (init_done)
   );

   always #5 ac97_bitclk = ~ac97_bitclk;

   // Free-running frame engine: one frame_start pulse every FRAME_LEN clocks.
   initial begin
      forever begin
         repeat (FRAME_LEN - 1) @(posedge ac97_bitclk);
         #1 frame_start = 1'b1;
         @(posedge ac97_bitclk);
         #1 frame_start = 1'b0;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic [1:0] valid, input logic [1:0] rd,
                                input logic [13:0] addr, input logic [31:0] wdata);
      req_valid = valid;
      req_read  = rd;
      req_addr  = addr;
      req_wdata = wdata;
   endtask

   task automatic tick();
      @(posedge ac97_bitclk);
      #1;
   endtask

   // Leaves the caller at the negedge just before the frame_start edge.
   task automatic waitFrameStart();
      int n = 0;
      @(negedge ac97_bitclk);
      while (!frame_start && n < 4 * FRAME_LEN) begin
         @(negedge ac97_bitclk);
         n++;
      end
      if (!frame_start) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL frame_wait: got no frame_start, expected one within %0d cycles", 4 * FRAME_LEN);
      end
   endtask

   // Transaction-level reference: who owns the channel, what the next frame carries, what gets acked.
   logic        m_link, m_on_air, m_read;
   int          m_init_sent, m_owner, m_rr, m_waited;
   logic [6:0]  m_idx;
   logic [15:0] m_wd;
   logic [1:0]  e_ack, prev_ack;
   logic [15:0] e_rdata;
   logic        e_err, e_cmd_valid, e_init_done;
   logic [19:0] e_cmd_addr, e_cmd_data;

   task automatic modelAck();
      e_ack   = (m_owner == 1) ? 2'b10 : 2'b01;
      m_owner = -1;
   endtask

   always @(negedge ac97_bitclk) begin
      if (rst) begin
         m_link = 1'b0; m_on_air = 1'b0; m_read = 1'b0; m_init_sent = 0;
         m_owner = -1; m_rr = 0; m_waited = 0; m_idx = '0; m_wd = '0;
         e_ack = 2'b00; e_rdata = '0; e_err = 1'b0; e_cmd_valid = 1'b0;
         e_init_done = 1'b0; e_cmd_addr = '0; e_cmd_data = '0;
      end
      checkOutput("req_ack", 32'(req_ack), 32'(e_ack));
      checkOutput("rsp_err", 32'(rsp_err), 32'(e_err));
      checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e_rdata));
      checkOutput("cmd_valid", 32'(cmd_valid), 32'(e_cmd_valid));
      checkOutput("init_done", 32'(init_done), 32'(e_init_done));
      if (e_cmd_valid || rst) begin
         checkOutput("cmd_addr", 32'(cmd_addr), 32'(e_cmd_addr));
         checkOutput("cmd_data", 32'(cmd_data), 32'(e_cmd_data));
      end
      if (!rst) begin
         prev_ack = e_ack;
         e_ack    = 2'b00;
         if (!m_link) begin
            if (frame_start && codec_ready) begin
               m_link = 1'b1; m_init_sent = 0; e_cmd_valid = 1'b1;
               e_cmd_addr = 20'(int'(tbl_idx[0]) * 4096);
               e_cmd_data = 20'(int'(tbl_data[0]) * 16);
            end
         end else if (frame_start && !codec_ready) begin
            if (m_owner >= 0) begin
               modelAck();
               e_err = 1'b1; e_rdata = 16'hFFFF;
            end
            m_owner = -1; m_on_air = 1'b0; m_link = 1'b0; e_cmd_valid = 1'b0; e_init_done = 1'b0;
         end else if (!e_init_done) begin
            if (frame_start) begin
               m_init_sent++;
               if (m_init_sent == 4) begin
                  e_cmd_valid = 1'b0; e_init_done = 1'b1;
               end else begin
                  e_cmd_addr = 20'(int'(tbl_idx[m_init_sent]) * 4096);
                  e_cmd_data = 20'(int'(tbl_data[m_init_sent]) * 16);
               end
            end
         end else if (m_owner < 0) begin
            if (req_valid != 2'b00 && prev_ack == 2'b00) begin
               m_owner  = req_valid[m_rr] ? m_rr : 1 - m_rr;
               m_rr     = 1 - m_owner;
               m_read   = req_read[m_owner];
               m_idx    = (m_owner == 1) ? req_addr[13:7] : req_addr[6:0];
               m_wd     = (m_owner == 1) ? req_wdata[31:16] : req_wdata[15:0];
               m_on_air = 1'b1;
               e_cmd_valid = 1'b1;
               e_cmd_addr  = 20'(int'(m_read) * 524288 + int'(m_idx) * 4096);
               e_cmd_data  = m_read ? 20'h0 : 20'(int'(m_wd) * 16);
            end
         end else if (m_on_air) begin
            if (frame_start) begin
               e_cmd_valid = 1'b0; m_on_air = 1'b0; m_waited = 0;
               if (!m_read) begin
                  modelAck();
                  e_err = 1'b0;
               end
            end
         end else begin
            if (sts_valid && sts_addr == m_idx) begin
               modelAck();
               e_rdata = sts_data; e_err = 1'b0;
            end else if (frame_start) begin
               m_waited++;
               if (m_waited == 4) begin
                  modelAck();
                  e_rdata = 16'hFFFF; e_err = 1'b1;
               end
            end
         end
      end
   end

   task automatic runInit();
      waitFrameStart();
      tick();
      for (int k = 0; k < 4; k++) begin
         waitFrameStart();
         checkOutput("init_cmd_valid", 32'(cmd_valid), 32'd1);
         checkOutput("init_cmd_addr", 32'(cmd_addr), 32'(exp_init_addr[k]));
         checkOutput("init_cmd_data", 32'(cmd_data), 32'(exp_init_data[k]));
         checkOutput("init_done_early", 32'(init_done), 32'd0);
         tick();
      end
      checkOutput("init_done_set", 32'(init_done), 32'd1);
      checkOutput("init_cmd_valid_off", 32'(cmd_valid), 32'd0);
   endtask

   initial begin
      #1 rst = 1'b1;
      repeat (3) tick();
      checkOutput("reset_ack", 32'(req_ack), 32'd0);
      checkOutput("reset_cmd_valid", 32'(cmd_valid), 32'd0);
      checkOutput("reset_init_done", 32'(init_done), 32'd0);
      rst = 1'b0;
      repeat (2 * FRAME_LEN) tick();
      codec_ready = 1'b1;
      runInit();

      // Host write 0x18 <- 0x1F1F
      applyStimulus(2'b01, 2'b00, {7'h00, 7'h18}, {16'h0000, 16'h1F1F});
      waitFrameStart();
      checkOutput("wr_cmd_addr", 32'(cmd_addr), 32'h18000);
      checkOutput("wr_cmd_data", 32'(cmd_data), 32'h1F1F0);
      tick();
      checkOutput("wr_ack", 32'(req_ack), 32'h1);
      checkOutput("wr_err", 32'(rsp_err), 32'h0);

      // Mixer read 0x26 with an unrelated status first
      applyStimulus(2'b10, 2'b10, {7'h26, 7'h00}, 32'h0);
      waitFrameStart();
      checkOutput("rd_cmd_addr", 32'(cmd_addr), 32'hA6000);
      checkOutput("rd_cmd_data", 32'(cmd_data), 32'h0);
      tick();
      sts_valid = 1'b1; sts_addr = 7'h20; sts_data = 16'hBEEF;
      tick();
      sts_valid = 1'b0;
      checkOutput("rd_ignore_ack", 32'(req_ack), 32'h0);
      tick();
      sts_valid = 1'b1; sts_addr = 7'h26; sts_data = 16'h000F;
      tick();
      sts_valid = 1'b0;
      checkOutput("rd_ack", 32'(req_ack), 32'h2);
      checkOutput("rd_rdata", 32'(rsp_rdata), 32'h000F);
      checkOutput("rd_err", 32'(rsp_err), 32'h0);

      // Host read 0x30 that never gets a status
      applyStimulus(2'b01, 2'b01, {7'h00, 7'h30}, 32'h0);
      waitFrameStart();
      checkOutput("to_cmd_addr", 32'(cmd_addr), 32'hB0000);
      tick();
      for (int i = 0; i < 3; i++) begin
         waitFrameStart();
         tick();
         checkOutput("to_early_ack", 32'(req_ack), 32'h0);
      end
      waitFrameStart();
      tick();
      checkOutput("to_ack", 32'(req_ack), 32'h1);
      checkOutput("to_err", 32'(rsp_err), 32'h1);
      checkOutput("to_rdata", 32'(rsp_rdata), 32'hFFFF);

      // Both requesters continuously valid: last grant was host, so mixer goes first
      applyStimulus(2'b11, 2'b00, {7'h04, 7'h02}, {16'h2222, 16'h1111});
      for (int i = 0; i < 4; i++) begin
         waitFrameStart();
         checkOutput("arb_cmd_addr", 32'(cmd_addr), (i % 2 == 0) ? 32'h04000 : 32'h02000);
         tick();
         checkOutput("arb_ack", 32'(req_ack), (i % 2 == 0) ? 32'h2 : 32'h1);
      end

      // Link drop while a mixer read waits for status
      applyStimulus(2'b10, 2'b10, {7'h26, 7'h00}, 32'h0);
      waitFrameStart();
      checkOutput("drop_cmd_addr", 32'(cmd_addr), 32'hA6000);
      tick();
      codec_ready = 1'b0;
      waitFrameStart();
      tick();
      checkOutput("drop_ack", 32'(req_ack), 32'h2);
      checkOutput("drop_err", 32'(rsp_err), 32'h1);
      checkOutput("drop_init_done", 32'(init_done), 32'h0);
      applyStimulus(2'b00, 2'b00, 14'h0, 32'h0);
      codec_ready = 1'b1;
      runInit();

      // Async reset while a host write is waiting for its frame
      applyStimulus(2'b01, 2'b00, {7'h00, 7'h18}, {16'h0000, 16'h5A5A});
      tick();
      checkOutput("rst_pre_cmd_valid", 32'(cmd_valid), 32'h1);
      rst = 1'b1;
      #1;
      checkOutput("rst_ack", 32'(req_ack), 32'h0);
      checkOutput("rst_rdata", 32'(rsp_rdata), 32'h0);
      checkOutput("rst_err", 32'(rsp_err), 32'h0);
      checkOutput("rst_cmd_valid", 32'(cmd_valid), 32'h0);
      checkOutput("rst_cmd_addr", 32'(cmd_addr), 32'h0);
      checkOutput("rst_cmd_data", 32'(cmd_data), 32'h0);
      checkOutput("rst_init_done", 32'(init_done), 32'h0);
      repeat (2) tick();
      applyStimulus(2'b00, 2'b00, 14'h0, 32'h0);
      rst = 1'b0;
      runInit();
      repeat (FRAME_LEN) tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got no completion, expected finish before 100000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
